// File: rtl/branch_controller.sv
// ---------------------------------------------------------------------------
// branch_controller
// Branch predictor and misprediction recovery controller.
//
// A 16-entry direct-mapped table is indexed by PC[5:2]. Each entry holds a
// 2-bit saturating counter, a valid bit and a 30-bit target. The table has
// no tag, so different PCs that share an index share an entry. The fetch
// side reads the table combinationally. The EX side resolves branches and
// jumps, updates the table, and launches a one-cycle redirect/flush pulse
// whenever the fetch-time prediction was wrong.
//
// Ports
//   clk, reset            : clock; synchronous active-high reset
//   if_pc                 : fetch PC used for the prediction lookup
//   pred_taken/target     : combinational prediction for if_pc
//   ex_valid              : EX stage holds a valid instruction
//   ex_is_branch/jump     : EX holds a conditional branch / JAL or JALR
//   branch_taken          : branch condition resolved in EX
//   ex_pc, ex_target      : EX PC and the computed target
//   ex_pred_taken/target  : prediction carried down from fetch
//   stall_in              : pipeline stalled; EX contents are held
//   pc_redirect           : load redirect_pc into the PC
//   redirect_pc           : correct-path PC
//   flush_ifid/idex/exmem : pipeline squash strobes
//   mispred_count         : saturating mispredict counter
// ---------------------------------------------------------------------------
module branch_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        branch_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic [31:0] ex_pred_target,
    input  logic        ex_pred_taken,
    input  logic        stall_in,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        flush_exmem,
    output logic [15:0] mispred_count
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic [1:0]  cnt_r [16];
    logic [15:0] vld_r;
    logic [29:0] tgt_r [16];

    logic [3:0]  if_idx_s;
    logic [3:0]  ex_idx_s;
    logic        resolve_s;
    logic        actual_taken_s;
    logic        mispredict_s;
    logic [1:0]  cnt_upd_s;
    logic [31:0] redirect_pc_r;
    logic [15:0] mispred_count_r;
    logic        unused_if_pc_bits_s;

    assign if_idx_s = if_pc[5:2];
    assign ex_idx_s = ex_pc[5:2];

    // Only the index bits of the fetch PC take part in the lookup.
    assign unused_if_pc_bits_s = ^{if_pc[31:6], if_pc[1:0]};

    // The lookup reads registered table state, so a same-index update in this
    // cycle becomes visible only after the edge.
    assign pred_taken  = vld_r[if_idx_s] & cnt_r[if_idx_s][1];
    assign pred_target = {tgt_r[if_idx_s], 2'b00};

    // Resolution is accepted only in IDLE, so wrong-path EX contents seen
    // during the redirect cycle are ignored.
    assign resolve_s      = ex_valid & (ex_is_branch | ex_is_jump) & ~stall_in & (state_r == IDLE);
    assign actual_taken_s = ex_is_jump | branch_taken;
    assign mispredict_s   = (actual_taken_s != ex_pred_taken) |
                            (actual_taken_s & ex_pred_taken & (ex_target != ex_pred_target));

    // Saturating counter step for the entry being resolved.
    always_comb begin
        cnt_upd_s = cnt_r[ex_idx_s];
        if (actual_taken_s) begin
            if (cnt_r[ex_idx_s] != 2'b11) begin
                cnt_upd_s = cnt_r[ex_idx_s] + 2'd1;
            end else begin
                cnt_upd_s = 2'b11;
            end
        end else begin
            if (cnt_r[ex_idx_s] != 2'b00) begin
                cnt_upd_s = cnt_r[ex_idx_s] - 2'd1;
            end else begin
                cnt_upd_s = 2'b00;
            end
        end
    end

    // Prediction table: counters reset to weakly-not-taken, entries invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                cnt_r[i] <= 2'b01;
                tgt_r[i] <= 30'd0;
            end
            vld_r <= 16'd0;
        end else if (resolve_s) begin
            cnt_r[ex_idx_s] <= cnt_upd_s;
            if (actual_taken_s) begin
                vld_r[ex_idx_s] <= 1'b1;
                tgt_r[ex_idx_s] <= ex_target[31:2];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: a mispredict costs exactly one redirect cycle.
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (resolve_s && mispredict_s) begin
                    state_next_s = REDIRECT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REDIRECT: state_next_s = IDLE;
            default:  state_next_s = IDLE;
        endcase
    end

    // FSM outputs: strobes are decoded straight from the state flop.
    always_comb begin
        pc_redirect = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        case (state_r)
            REDIRECT: begin
                pc_redirect = 1'b1;
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                flush_exmem = 1'b1;
            end
            IDLE:    pc_redirect = 1'b0;
            default: pc_redirect = 1'b0;
        endcase
    end

    // Correct-path PC and mispredict statistics, captured at the mispredict edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_pc_r   <= 32'd0;
            mispred_count_r <= 16'd0;
        end else if (resolve_s && mispredict_s) begin
            redirect_pc_r <= actual_taken_s ? ex_target : (ex_pc + 32'd4);
            if (mispred_count_r != 16'hFFFF) begin
                mispred_count_r <= mispred_count_r + 16'd1;
            end
        end
    end

    assign redirect_pc   = redirect_pc_r;
    assign mispred_count = mispred_count_r;

endmodule
